// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Interlock and redirect sequencer for the 5-stage SimpleRISC core. It drives
// the pipeline-register write enables, the bubble/flush controls and the PC
// mux. It resolves load-use hazards, taken EX branches, multi-cycle div/mod
// occupancy of EX, and data-memory wait states.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_count performance counter outputs.
//
// Parameters:
//   DIV_LATENCY      total cycles a div/mod occupies EX (1..16, 1 = no stall)
//
// Ports:
//   clk              core clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   id_inst[31:0]    instruction in ID (op[31:27] I[26] rd[25:22] rs1[21:18] rs2[17:14])
//   id_valid         ID holds a real instruction
//   ex_inst[31:0]    instruction in EX
//   ex_valid         EX holds a real instruction
//   ex_branch_taken  branch unit resolved a taken branch in EX
//   ex_branch_target[31:0] redirect address for the EX branch
//   mem_busy         data memory not ready this cycle
//   pc_write         PC load enable
//   pc_sel           1 selects pc_redirect, 0 selects PC+4
//   pc_redirect[31:0] ex_branch_target while pc_sel=1, else 0
//   if_id_write / id_ex_write / ex_mem_write   pipeline register load enables
//   if_id_flush / id_ex_bubble / ex_mem_bubble / mem_wb_bubble  nop inserts
//   busy             FSM is in MULTI
//   stall_cycles[31:0], flush_count[31:0]  (HAZARD_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int DIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic [31:0] ex_inst,
  input  logic        ex_valid,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        pc_sel,
  output logic [31:0] pc_redirect,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        mem_wb_bubble,
  output logic        busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [4:0] OP_NOT = 5'b01000;
  localparam logic [4:0] OP_MOV = 5'b01001;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;
  localparam logic [4:0] OP_LD  = 5'b01110;
  localparam logic [4:0] OP_ST  = 5'b01111;
  localparam logic [4:0] OP_RET = 5'b10100;
  localparam logic [4:0] OP_ALU_LAST = 5'b01100;

  // With DIV_LATENCY==1 the divider never stalls, so the counter load value
  // is irrelevant; clamp it to avoid a negative constant.
  localparam bit         DIV_STALLS = (DIV_LATENCY > 1);
  localparam logic [3:0] CNT_INIT   = DIV_STALLS ? 4'(DIV_LATENCY - 2) : 4'd0;

  typedef enum logic {RUN, MULTI} state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;

  // ID field decode
  logic [4:0] id_op;
  logic       id_imm;
  logic [3:0] id_rd;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic [4:0] ex_op;
  logic [3:0] ex_dst;

  assign id_op  = id_inst[31:27];
  assign id_imm = id_inst[26];
  assign id_rd  = id_inst[25:22];
  assign id_rs1 = id_inst[21:18];
  assign id_rs2 = id_inst[17:14];
  assign ex_op  = ex_inst[31:27];
  assign ex_dst = ex_inst[25:22];

  // Fields that play no part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^{id_inst[13:0], ex_inst[26], ex_inst[21:0]};

  logic alu_op;
  logic reads_rs1;
  logic reads_rs2;
  logic reads_rd;
  logic reads_r15;
  logic lu;
  logic dv;
  logic hold;

  always_comb begin
    alu_op    = (id_op <= OP_ALU_LAST);
    reads_rs1 = (alu_op && id_op != OP_NOT && id_op != OP_MOV) ||
                id_op == OP_LD || id_op == OP_ST;
    // not/mov are inside the ALU range, so they read rs2 in register form too.
    reads_rs2 = alu_op && !id_imm;
    reads_rd  = (id_op == OP_ST);
    reads_r15 = (id_op == OP_RET);

    lu = ex_valid && id_valid && (ex_op == OP_LD) &&
         ((reads_rs1 && id_rs1 == ex_dst) ||
          (reads_rs2 && id_rs2 == ex_dst) ||
          (reads_rd  && id_rd  == ex_dst) ||
          (reads_r15 && ex_dst == 4'd15));

    dv   = ex_valid && (ex_op == OP_DIV || ex_op == OP_MOD) && DIV_STALLS;
    // A div/mod is only detected in RUN; in MULTI the counter alone decides,
    // so the instruction is never re-detected on its release cycle.
    hold = (state_reg == RUN && dv) || (state_reg == MULTI && cnt_reg != 4'd0);
  end

  // State and occupancy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (dv) begin
            state_reg <= MULTI;
            cnt_reg   <= CNT_INIT;
          end
        end
        MULTI: begin
          // The countdown keeps running through memory waits; only the exit
          // from MULTI waits for the memory to become ready.
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (!mem_busy) begin
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= 4'd0;
        end
      endcase
    end
  end

  assign busy = (state_reg == MULTI);

  // Prioritised pipeline control
  always_comb begin
    pc_write      = 1'b1;
    pc_sel        = 1'b0;
    pc_redirect   = 32'd0;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      // Whole pipe frozen; a taken branch in EX stays there and redirects later.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (hold) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (ex_valid && ex_branch_taken) begin
      // The ID instruction is squashed, so a coincident load-use is moot.
      pc_sel       = 1'b1;
      pc_redirect  = ex_branch_target;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_write && stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (pc_sel && flush_count != 32'hFFFF_FFFF) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule
